// File: rtl/montmul_seq_if.sv
// Operand/result handshake bundle for montmul_seq: the requester drives the
// operands and start, the multiplier returns busy/done/err and the result.
interface montmul_seq_if #(
    parameter int WID = 256
);
    logic [WID-1:0] a;
    logic [WID-1:0] b;
    logic [WID-1:0] m;
    logic           start;
    logic           busy;
    logic           done;
    logic           err;
    logic [WID-1:0] r;

    modport master (
        output a, b, m, start,
        input  busy, done, err, r
    );

    modport slave (
        input  a, b, m, start,
        output busy, done, err, r
    );
endinterface

// File: rtl/montmul_seq.sv
// Bit-serial radix-2 Montgomery multiplier: r = a*b*2^-WID mod m, one
// multiplier bit per cycle, registered final subtraction, even-modulus flag.
module montmul_seq #(
    parameter int WID    = 256,
    parameter int CNTWID = 8
) (
    input  logic         clk,
    input  logic         rst,
    montmul_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SUB  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNTWID-1:0] cnt_q, cnt_d;
    logic [WID-1:0]    a_q, a_d;
    logic [WID-1:0]    b_q, b_d;
    logic [WID-1:0]    m_q, m_d;
    logic [WID-1:0]    r_q, r_d;
    logic [WID+1:0]    s_q, s_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [WID+1:0]    sum_ab;
    logic [WID+1:0]    sum_abm;
    logic              q_bit;

    // A is shifted right each iteration so the current multiplier bit is a_q[0].
    always_comb begin
        sum_ab  = s_q + (a_q[0] ? {2'b00, b_q} : '0);
        q_bit   = sum_ab[0];
        sum_abm = sum_ab + (q_bit ? {2'b00, m_q} : '0);
    end

    // NOTE: every variable gets its hold/default value first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        s_d     = s_q;
        r_d     = r_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    m_d     = bus.m;
                    s_d     = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = bus.m[0] ? RUN : SUB;
                end
            end
            RUN: begin
                s_d   = sum_abm >> 1;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CNTWID'(1);
                if (cnt_q == CNTWID'(WID - 1)) begin
                    state_d = SUB;
                end
            end
            SUB: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (!m_q[0]) begin
                    r_d   = '0;
                    err_d = 1'b1;
                end else if (s_q >= {2'b00, m_q}) begin
                    // S < 2M, so the difference fits in WID bits.
                    r_d = s_q[WID-1:0] - m_q;
                end else begin
                    r_d = s_q[WID-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // NOTE: operand and accumulator registers are loaded on accept before use, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
        m_q <= m_d;
        s_q <= s_d;
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.r    = r_q;

endmodule

// File: tb/tb_montmul_seq.sv
// Bench for montmul_seq: directed vector table, multi-cycle corner sequences
// and randomized operations against a brute-force modular reference model.
module tb_montmul_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    montmul_seq_if #(.WID(4)) if4 ();
    montmul_seq_if #(.WID(8)) if8 ();

    montmul_seq #(.WID(4), .CNTWID(3)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
    montmul_seq #(.WID(8), .CNTWID(4)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int w;
        int a;
        int b;
        int m;
        int exp_r;
        int exp_err;
        int exp_lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // r is the unique value in [0,m) with r*2^w == a*b (mod m).
    function automatic int model_r(input int w, input int a, input int b, input int m);
        int ab = (a * b) % m;
        int p  = (1 << w) % m;
        for (int x = 0; x < m; x++) begin
            if ((x * p) % m == ab) return x;
        end
        return -1;
    endfunction

    task automatic drive(input int w, input int a, input int b, input int m, input logic st);
        if (w == 4) begin
            if4.a = 4'(a); if4.b = 4'(b); if4.m = 4'(m); if4.start = st;
        end else begin
            if8.a = 8'(a); if8.b = 8'(b); if8.m = 8'(m); if8.start = st;
        end
    endtask

    task automatic set_start(input int w, input logic st);
        if (w == 4) if4.start = st;
        else        if8.start = st;
    endtask

    task automatic sample(input int w, output int busy, output int done, output int err, output int r);
        if (w == 4) begin
            busy = int'(if4.busy); done = int'(if4.done); err = int'(if4.err); r = int'(if4.r);
        end else begin
            busy = int'(if8.busy); done = int'(if8.done); err = int'(if8.err); r = int'(if8.r);
        end
    endtask

    // Starts one operation (DUT must be idle) and waits, bounded, for done.
    task automatic run_op(input int w, input int a, input int b, input int m,
                          output int r, output int err, output int lat,
                          output int bcnt, output int ovl);
        int busy, done, e, rr;
        drive(w, a, b, m, 1'b1);
        @(posedge clk); #1;
        set_start(w, 1'b0);
        sample(w, busy, done, e, rr);
        bcnt = busy; lat = 0; r = -1; err = -1; ovl = 0;
        while (lat < 64) begin
            @(posedge clk); #1;
            lat++;
            sample(w, busy, done, e, rr);
            if (busy != 0 && done != 0) ovl = 1;
            if (done != 0) begin
                r = rr; err = e;
                break;
            end
            if (busy != 0) bcnt++;
        end
    endtask

    initial begin
        vec_t tbl[7];
        int r, err, lat, bcnt, ovl;
        int busy, done;

        tbl[0] = '{4, 7, 11, 13, 4, 0, 5};
        tbl[1] = '{4, 3, 5, 14, 0, 1, 1};
        tbl[2] = '{4, 0, 5, 13, 0, 0, 5};
        tbl[3] = '{8, 1, 1, 255, 1, 0, 9};
        tbl[4] = '{8, 255, 254, 255, 0, 0, 9};
        tbl[5] = '{4, 1, 1, 13, 9, 0, 5};
        tbl[6] = '{4, 12, 12, 13, 9, 0, 5};

        rst = 1'b1;
        drive(4, 0, 0, 1, 1'b0);
        drive(8, 0, 0, 1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int w = 4; w <= 8; w += 4) begin
            sample(w, busy, done, err, r);
            check($sformatf("reset_busy_w%0d", w), busy, 0);
            check($sformatf("reset_done_w%0d", w), done, 0);
            check($sformatf("reset_err_w%0d", w), err, 0);
            check($sformatf("reset_r_w%0d", w), r, 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].m, r, err, lat, bcnt, ovl);
            check($sformatf("vec%0d_r", i), r, tbl[i].exp_r);
            check($sformatf("vec%0d_err", i), err, tbl[i].exp_err);
            check($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, tbl[i].exp_lat);
            check($sformatf("vec%0d_busy_done_overlap", i), ovl, 0);
        end

        // Back-to-back with start held high
        begin
            int nd = 0, e1 = -1, e2 = -1, r1 = -1, r2 = -1, prev = 0, dbl = 0, ov = 0;
            drive(4, 1, 1, 13, 1'b1);
            @(posedge clk); #1;
            drive(4, 12, 12, 13, 1'b1);
            for (int e = 1; e <= 30; e++) begin
                @(posedge clk); #1;
                sample(4, busy, done, err, r);
                if (done != 0 && prev != 0) dbl = 1;
                if (done != 0 && busy != 0) ov = 1;
                if (done != 0) begin
                    nd++;
                    if (nd == 1) begin e1 = e; r1 = r; end
                    else if (nd == 2) begin e2 = e; r2 = r; end
                end
                if (nd >= 1 && busy != 0) set_start(4, 1'b0);
                prev = done;
            end
            check("b2b_done_count", nd, 2);
            check("b2b_first_edge", e1, 5);
            check("b2b_done_spacing", e2 - e1, 6);
            check("b2b_r1", r1, 9);
            check("b2b_r2", r2, 9);
            check("b2b_double_done", dbl, 0);
            check("b2b_busy_done_overlap", ov, 0);
        end

        // Start pulses and operand changes while busy are ignored
        begin
            int nd = 0, e1 = -1, r1 = -1;
            drive(4, 7, 11, 13, 1'b1);
            @(posedge clk); #1;
            drive(4, 7, 11, 13, 1'b0);
            for (int e = 1; e <= 15; e++) begin
                @(posedge clk); #1;
                sample(4, busy, done, err, r);
                if (done != 0) begin
                    nd++;
                    if (nd == 1) begin e1 = e; r1 = r; end
                end
                if (e == 1 || e == 2)
                    drive(4, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), 1'b1);
                else if (e == 3)
                    set_start(4, 1'b0);
            end
            check("ignore_done_count", nd, 1);
            check("ignore_done_edge", e1, 5);
            check("ignore_r", r1, 4);
        end

        // Synchronous reset in the middle of the iterations
        begin
            int nd = 0;
            drive(4, 7, 11, 13, 1'b1);
            @(posedge clk); #1;
            set_start(4, 1'b0);
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            sample(4, busy, done, err, r);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_err", err, 0);
            check("abort_r", r, 0);
            rst = 1'b0;
            for (int e = 0; e < 10; e++) begin
                @(posedge clk); #1;
                sample(4, busy, done, err, r);
                if (done != 0) nd++;
            end
            check("abort_no_done", nd, 0);
            run_op(4, 7, 11, 13, r, err, lat, bcnt, ovl);
            check("after_abort_r", r, 4);
            check("after_abort_lat", lat, 5);
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            int w, m, a, b, er, ee, el;
            w = (i % 2 != 0) ? 8 : 4;
            a = int'($urandom_range(0, (1 << w) - 1));
            if ($urandom_range(0, 9) == 0) begin
                m  = int'($urandom_range(0, (1 << w) - 1)) & ~1;
                b  = int'($urandom_range(0, (1 << w) - 1));
                er = 0; ee = 1; el = 1;
            end else begin
                m  = int'($urandom_range(0, (1 << w) - 1)) | 1;
                b  = int'($urandom_range(0, m - 1));
                er = model_r(w, a, b, m); ee = 0; el = w + 1;
            end
            run_op(w, a, b, m, r, err, lat, bcnt, ovl);
            check($sformatf("rnd%0d_w%0d_a%0d_b%0d_m%0d_r", i, w, a, b, m), r, er);
            check($sformatf("rnd%0d_err", i), err, ee);
            check($sformatf("rnd%0d_lat", i), lat, el);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
